// File: rtl/register_file.sv
// 32 x 32-bit integer register file for the RV32IM pipeline: two combinational
// read ports with same-cycle write bypass, one clocked write port, x0 tied to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  writeenable,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // No handshake: one write and two reads are accepted every cycle, no stall.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_active;

  // Written as an if so an unknown strobe resolves to "no write" in simulation.
  always_comb begin
    write_active = 1'b0;
    if (!rst && writeenable) begin
      write_active = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_active && (reg_write != '0)) begin
      regs[reg_write] <= write_data;
    end
  end

  always_comb begin
    if (read1 == '0) begin
      read_data1 = '0;
    end else if (write_active && (reg_write == read1)) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs[read1];
    end
  end

  always_comb begin
    if (read2 == '0) begin
      read_data2 = '0;
    end else if (write_active && (reg_write == read2)) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs[read2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: drives one write and two reads per cycle, predicts
// read data from a reference model and checks it through an expected queue.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  reg_write;
  logic [31:0] write_data;
  logic        writeenable;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int tests_run;
  int tests_failed;

  logic [31:0] model [32];
  logic [31:0] exp_q[$];

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_data (write_data),
    .writeenable(writeenable),
    .read1      (read1),
    .read2      (read2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rst_v, input logic we_v,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (rst_v === 1'b0 && we_v === 1'b1 && wa == idx) return wd;
    return model[idx];
  endfunction

  // Driver: present one cycle of stimulus, check reads before the edge, then
  // let the edge happen and update the model.
  task automatic apply(input string tag, input logic rst_v, input logic we_v,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst         = rst_v;
    writeenable = we_v;
    reg_write   = wa;
    write_data  = wd;
    read1       = r1;
    read2       = r2;
    exp_q.push_back(model_read(rst_v, we_v, wa, wd, r1));
    exp_q.push_back(model_read(rst_v, we_v, wa, wd, r2));
    #2;
    check_eq({tag, "_rd1"}, read_data1, exp_q.pop_front());
    check_eq({tag, "_rd2"}, read_data2, exp_q.pop_front());
    @(posedge clk);
    if (rst_v === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we_v === 1'b1 && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    logic [4:0]  wa_r, r1_r, r2_r;
    logic [31:0] wd_r;
    logic        we_r;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    writeenable  = 1'b0;
    reg_write    = 5'd0;
    write_data   = 32'h0;
    read1        = 5'd0;
    read2        = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset, then nonzero indices read zero
    apply("rst",   1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    apply("t1",    1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);

    // Write then read back
    apply("t2w",   1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd7);
    apply("t2r",   1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Writes to x0 discarded
    apply("t3w",   1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    apply("t3r",   1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);

    // Dual-port same-cycle bypass
    apply("t4b",   1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    apply("t4r",   1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);

    // Fill all registers, each write bypassed on port 1
    for (int i = 1; i < 32; i++) begin
      apply("t5f", 1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1));
    end
    // Reset wins over a write and suppresses bypass
    apply("t5rst", 1'b1, 1'b1, 5'd4, 32'hFFFFFFFF, 5'd4, 5'd5);
    for (int i = 0; i < 32; i++) begin
      apply("t5z", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    end

    // writeenable=0 leaves the target unchanged
    apply("t6w",   1'b0, 1'b1, 5'd9, 32'h0000_9999, 5'd0, 5'd0);
    apply("t6n",   1'b0, 1'b0, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd9);
    apply("t6r",   1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);

    // Random traffic against the model
    for (int n = 0; n < 20; n++) begin
      we_r = 1'($urandom_range(0, 1));
      wa_r = 5'($urandom_range(0, 31));
      wd_r = $urandom;
      r1_r = ($urandom_range(0, 3) == 0) ? wa_r : 5'($urandom_range(0, 31));
      r2_r = 5'($urandom_range(0, 31));
      apply("rnd", 1'b0, we_r, wa_r, wd_r, r1_r, r2_r);
    end
    for (int i = 0; i < 32; i++) begin
      apply("rndrb", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
